atvp_load_ctrl: RTL and testbench

Output stage placed directly downstream of the `atvp002` decoder. It consumes the decoder's `TV`, `PC` and `AL` levels and turns them into relay drives with a minimum switching interval. It also runs an alarm latch that produces a pulsed buzzer output and holds until acknowledged. While an alarm is active, both loads are forced off.

---
 rtl/atvp_load_ctrl.sv | 134 +++++++++++++
 tb/tb_atvp_load_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/atvp_load_ctrl.sv
// Relay drive stage with minimum switching interval and a latched, pulsed alarm buzzer.
// Optional macro ATVP_SYNC_EN adds a 2-flop synchronizer on TV, PC, AL and ACK.
module atvp_load_ctrl #(
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned BEEP_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic TV,
  input  logic PC,
  input  logic AL,
  input  logic ACK,
  output logic TV_EN,
  output logic PC_EN,
  output logic BUZ,
  output logic AL_LATCH
);

  localparam int unsigned HW = $clog2(HOLD_CYC);
  localparam int unsigned BW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);
  localparam logic [BW-1:0] BEEP_MAX = BW'(BEEP_CYC - 1);

  typedef enum logic [1:0] {IDLE, RING, SILENT} state_t;

  logic tv_s, pc_s, al_s, ack_s;

`ifdef ATVP_SYNC_EN
  logic [3:0] meta_q, sync_q;

  // Two-stage synchronizer; every internal decision uses sync_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {TV, PC, AL, ACK};
      sync_q <= meta_q;
    end
  end

  assign {tv_s, pc_s, al_s, ack_s} = sync_q;
`else
  assign {tv_s, pc_s, al_s, ack_s} = {TV, PC, AL, ACK};
`endif

  state_t          state_q;
  logic            buz_q, latch_q;
  logic [BW-1:0]   beep_q;
  logic [1:0]      req, en_q;
  logic [HW-1:0]   cnt_q [2];
  logic            force_off;

  // Any alarm activity (present or latched) overrides the hold time to drop loads.
  assign force_off = (state_q != IDLE) || al_s;
  assign req       = {tv_s, pc_s};

  // Relay channels: index 1 is TV, index 0 is PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= HOLD_MAX;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (force_off && en_q[i]) begin
          en_q[i]  <= 1'b0;
          cnt_q[i] <= '0;
        end else if (!force_off && (req[i] != en_q[i]) && (cnt_q[i] == HOLD_MAX)) begin
          en_q[i]  <= req[i];
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != HOLD_MAX) begin
          cnt_q[i] <= cnt_q[i] + HW'(1);
        end
      end
    end
  end

  // Alarm latch FSM with registered buzzer and latch indicator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buz_q   <= 1'b0;
      latch_q <= 1'b0;
      beep_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          buz_q   <= 1'b0;
          latch_q <= 1'b0;
          if (al_s) begin
            state_q <= RING;
            buz_q   <= 1'b1;
            latch_q <= 1'b1;
            beep_q  <= '0;
          end
        end
        RING: begin
          if (ack_s) begin
            buz_q <= 1'b0;
            if (al_s) begin
              state_q <= SILENT;
            end else begin
              state_q <= IDLE;
              latch_q <= 1'b0;
            end
          end else if (beep_q == BEEP_MAX) begin
            beep_q <= '0;
            buz_q  <= ~buz_q;
          end else begin
            beep_q <= beep_q + BW'(1);
          end
        end
        SILENT: begin
          buz_q <= 1'b0;
          if (!al_s) begin
            state_q <= IDLE;
            latch_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          buz_q   <= 1'b0;
          latch_q <= 1'b0;
        end
      endcase
    end
  end

  assign TV_EN    = en_q[1];
  assign PC_EN    = en_q[0];
  assign BUZ      = buz_q;
  assign AL_LATCH = latch_q;

endmodule

// File: tb/tb_atvp_load_ctrl.sv
// Self-checking bench for atvp_load_ctrl: timestamp-based reference model, directed plan, random soak.
module tb_atvp_load_ctrl;

  localparam int H = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic TV = 1'b0, PC = 1'b0, AL = 1'b0, ACK = 1'b0;
  logic TV_EN, PC_EN, BUZ, AL_LATCH;

  int vectors = 0;
  int miscompares = 0;

  atvp_load_ctrl #(.HOLD_CYC(H), .BEEP_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .TV(TV), .PC(PC), .AL(AL), .ACK(ACK),
    .TV_EN(TV_EN), .PC_EN(PC_EN), .BUZ(BUZ), .AL_LATCH(AL_LATCH)
  );

  always #5 clk = ~clk;

  // Reference model: edge counter, time of last relay change, alarm mode, ring start time.
  int   cyc = 0;
  int   tv_last = -1000, pc_last = -1000, ring_t = 0;
  int   mode = 0;  // 0 no alarm, 1 ringing, 2 silenced
  logic m_tv = 0, m_pc = 0, m_buz = 0, m_lat = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chan(input logic frc, input logic req, inout logic en, inout int last);
    if (frc && en) begin
      en = 0; last = cyc;
    end else if (!frc && req != en && (cyc - last) >= H) begin
      en = req; last = cyc;
    end
  endtask

  task automatic model_edge(input logic r, t, p, a, k);
    logic frc;
    cyc++;
    if (!r) begin
      m_tv = 0; m_pc = 0; mode = 0;
      tv_last = cyc - H; pc_last = cyc - H;
    end else begin
      frc = (mode != 0) || a;
      chan(frc, t, m_tv, tv_last);
      chan(frc, p, m_pc, pc_last);
      case (mode)
        0: if (a) begin mode = 1; ring_t = cyc; end
        1: if (k) mode = a ? 2 : 0;
        default: if (!a) mode = 0;
      endcase
    end
    m_lat = (mode != 0);
    m_buz = (mode == 1) && ((((cyc - ring_t) / B) % 2) == 0);
  endtask

  // Apply one input vector across one edge, then compare DUT against the model.
  task automatic step(input logic r, t, p, a, k);
    rst_n = r; TV = t; PC = p; AL = a; ACK = k;
    @(posedge clk);
    model_edge(r, t, p, a, k);
    #1;
    chk("tv_en", TV_EN, m_tv);
    chk("pc_en", PC_EN, m_pc);
    chk("buz", BUZ, m_buz);
    chk("al_latch", AL_LATCH, m_lat);
  endtask

  logic bp [9];
  logic rt, rp, ra, rk, rr;

  initial begin
    bp[0] = 1; bp[1] = 1; bp[2] = 1; bp[3] = 1;
    bp[4] = 0; bp[5] = 0; bp[6] = 0; bp[7] = 0; bp[8] = 1;
    @(negedge clk);

    // 1: reset with all inputs high, then first request accepted at once
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    chk("rst_tv", TV_EN, 0); chk("rst_pc", PC_EN, 0);
    chk("rst_buz", BUZ, 0);  chk("rst_lat", AL_LATCH, 0);
    step(1, 1, 0, 0, 0);
    chk("rel_tv", TV_EN, 1);

    // 2: hold interval and short pulse rejection
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < H; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);                     // edge 0
    chk("hold_tv_on", TV_EN, 1); chk("hold_pc_on", PC_EN, 1);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int e = 3; e <= 7; e++) begin
      step(1, 0, (e == 3) ? 1'b0 : 1'b1, 0, 0);
      chk("hold_tv_kept", TV_EN, 1);
    end
    step(1, 0, 1, 0, 0);                     // edge 8
    chk("hold_tv_off", TV_EN, 0); chk("pulse_pc_kept", PC_EN, 1);
    step(1, 0, 1, 0, 0);
    chk("pulse_pc_kept2", PC_EN, 1);

    // 3: forced off and buzzer pattern
    for (int i = 0; i < H + 1; i++) step(1, 1, 1, 0, 0);
    chk("both_on_tv", TV_EN, 1); chk("both_on_pc", PC_EN, 1);
    step(1, 1, 1, 1, 0);
    chk("force_tv", TV_EN, 0); chk("force_pc", PC_EN, 0);
    chk("force_lat", AL_LATCH, 1); chk("buz_pat0", BUZ, bp[0]);
    for (int i = 1; i < 9; i++) begin
      step(1, 1, 1, 1, 0);
      chk("buz_pat", BUZ, bp[i]);
    end

    // 4: acknowledge with alarm present, then release
    step(1, 1, 0, 1, 1);
    chk("sil_buz", BUZ, 0); chk("sil_lat", AL_LATCH, 1); chk("sil_tv", TV_EN, 0);
    step(1, 1, 0, 1, 0);
    chk("sil_hold_lat", AL_LATCH, 1); chk("sil_hold_buz", BUZ, 0);
    step(1, 1, 0, 0, 0);
    chk("idle_lat", AL_LATCH, 0); chk("idle_tv_still_off", TV_EN, 0);
    step(1, 1, 0, 0, 0);
    chk("tv_back_on", TV_EN, 1);

    // 5: one-cycle alarm pulse stays latched until ACK
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 50; i++) begin
      step(1, 0, 0, 0, 0);
      chk("latched_lat", AL_LATCH, 1);
    end
    step(1, 0, 0, 0, 1);
    chk("ack_buz", BUZ, 0); chk("ack_lat", AL_LATCH, 0);

    // 6: reset while ringing
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    chk("rring_buz", BUZ, 0); chk("rring_lat", AL_LATCH, 0); chk("rring_tv", TV_EN, 0);
    step(1, 1, 0, 0, 0);
    chk("rring_idle_lat", AL_LATCH, 0); chk("rring_tv_on", TV_EN, 1);

    // Random soak with sticky levels
    rt = 0; rp = 0; ra = 0; rk = 0; rr = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) rt = ~rt;
      if ($urandom_range(5) == 0) rp = ~rp;
      if (ra) ra = ($urandom_range(7) != 0);
      else    ra = ($urandom_range(39) == 0);
      rk = ($urandom_range(9) == 0);
      rr = ($urandom_range(299) != 0);
      step(rr, rt, rp, ra, rk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
